// File: rtl/fetch_queue_pkg.sv
// Shared pipeline constants and the fetch-queue entry layout.
package fetch_queue_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;  // addi x0,x0,0

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fq_entry_t;
endpackage

// File: rtl/sync_fifo.sv
// Generic first-word-fall-through FIFO with synchronous clear.
// Caller must not push when full unless it also pops in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     empty,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wr_ptr, rd_ptr;

  assign rdata = mem[rd_ptr];
  assign empty = (level == '0);
  assign full  = (level == (AW+1)'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  // Storage carries no reset; level gates every read.
  always_ff @(posedge clk) begin
    if (push && !clr) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction queue: FWFT buffer plus flush, back-pressure
// and NOP-on-empty handling.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int              DEPTH     = 2,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [XLEN-1:0]        pc_f,
  input  logic [XLEN-1:0]        instruction_f,
  input  logic                   mem_valid_f,
  output logic                   stall_f,
  input  logic                   branch_d,
  input  logic                   pc_write_m,
  input  logic                   stall_d,
  output logic [XLEN-1:0]        pc_d,
  output logic [XLEN-1:0]        instruction_d,
  output logic                   valid_d,
  output logic [$clog2(DEPTH):0] level
);
  fq_entry_t wr_ent, rd_ent;
  logic      flush, full, empty, pop, push;

  assign flush  = branch_d | pc_write_m;
  assign pop    = valid_d & ~stall_d;
  assign push   = mem_valid_f & ~flush & (~full | pop);
  assign wr_ent = '{pc: pc_f, instr: instruction_f};

  sync_fifo #(
    .WIDTH($bits(fq_entry_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .push  (push),
    .pop   (pop),
    .wdata (wr_ent),
    .rdata (rd_ent),
    .level (level),
    .empty (empty),
    .full  (full)
  );

  assign valid_d       = ~empty;
  assign pc_d          = empty ? '0 : rd_ent.pc;
  assign instruction_d = empty ? NOP_INSTR : rd_ent.instr;

  // A redirect must never see stall_f high, since fetch would drop it.
  // Reset holds fetch regardless of the other inputs.
  assign stall_f = ~rst_n | (~flush & (~mem_valid_f | (full & ~pop)));
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed vector table, async reset
// sequence, then random traffic against a queue-based reference model.
module tb_fetch_queue;
  localparam int DEPTH = 2;
  localparam logic [31:0] NOPI = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_f, instruction_f, pc_d, instruction_d;
  logic        mem_valid_f, stall_f, branch_d, pc_write_m, stall_d, valid_d;
  logic [$clog2(DEPTH):0] level;

  int checks = 0;
  int errors = 0;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_f          (pc_f),
    .instruction_f (instruction_f),
    .mem_valid_f   (mem_valid_f),
    .stall_f       (stall_f),
    .branch_d      (branch_d),
    .pc_write_m    (pc_write_m),
    .stall_d       (stall_d),
    .pc_d          (pc_d),
    .instruction_d (instruction_d),
    .valid_d       (valid_d),
    .level         (level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mv;
    logic [31:0] pc;
    logic [31:0] ins;
    logic        br;
    logic        pw;
    logic        sd;
    logic        e_v;
    logic [31:0] e_pc;
    logic [31:0] e_ins;
    int          e_lvl;
    logic        e_st;
  } vec_t;

  vec_t tv[22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic ev, input logic [31:0] epc,
                         input logic [31:0] eins, input int elvl, input logic est);
    chk({tag, ".valid_d"},       {31'd0, valid_d}, {31'd0, ev});
    chk({tag, ".pc_d"},          pc_d, epc);
    chk({tag, ".instruction_d"}, instruction_d, eins);
    chk({tag, ".level"},         32'(level), 32'(elvl));
    chk({tag, ".stall_f"},       {31'd0, stall_f}, {31'd0, est});
  endtask

  task automatic drive(input logic mv, input logic [31:0] pc, input logic [31:0] ins,
                       input logic br, input logic pw, input logic sd);
    mem_valid_f = mv; pc_f = pc; instruction_f = ins;
    branch_d = br; pc_write_m = pw; stall_d = sd;
  endtask

  // Reference: a plain queue of {pc,instr}; outputs derived from its size.
  logic [63:0] q[$];

  initial begin
    //          mv pc       ins      br pw sd   v  pc       ins      lvl st
    tv[0]  = '{0, 32'h00, 32'h00, 0, 0, 0,   0, 32'h00, NOPI,   0, 1};
    tv[1]  = '{1, 32'h00, 32'hA0, 0, 0, 0,   0, 32'h00, NOPI,   0, 0};
    tv[2]  = '{1, 32'h04, 32'hA4, 0, 0, 0,   1, 32'h00, 32'hA0, 1, 0};
    tv[3]  = '{1, 32'h08, 32'hA8, 0, 0, 0,   1, 32'h04, 32'hA4, 1, 0};
    tv[4]  = '{0, 32'h00, 32'h00, 0, 0, 0,   1, 32'h08, 32'hA8, 1, 1};
    tv[5]  = '{0, 32'h00, 32'h00, 0, 0, 0,   0, 32'h00, NOPI,   0, 1};
    tv[6]  = '{1, 32'h00, 32'hA0, 0, 0, 1,   0, 32'h00, NOPI,   0, 0};
    tv[7]  = '{1, 32'h04, 32'hA4, 0, 0, 1,   1, 32'h00, 32'hA0, 1, 0};
    tv[8]  = '{1, 32'h08, 32'hA8, 0, 0, 1,   1, 32'h00, 32'hA0, 2, 1};
    tv[9]  = '{1, 32'h08, 32'hA8, 0, 0, 0,   1, 32'h00, 32'hA0, 2, 0};
    tv[10] = '{0, 32'h00, 32'h00, 0, 0, 0,   1, 32'h04, 32'hA4, 2, 1};
    tv[11] = '{0, 32'h00, 32'h00, 0, 0, 0,   1, 32'h08, 32'hA8, 1, 1};
    tv[12] = '{1, 32'h10, 32'hB0, 0, 0, 1,   0, 32'h00, NOPI,   0, 0};
    tv[13] = '{1, 32'h14, 32'hB4, 0, 0, 1,   1, 32'h10, 32'hB0, 1, 0};
    tv[14] = '{1, 32'h18, 32'hB8, 1, 0, 0,   1, 32'h10, 32'hB0, 2, 0};
    tv[15] = '{0, 32'h00, 32'h00, 0, 0, 0,   0, 32'h00, NOPI,   0, 1};
    tv[16] = '{1, 32'h20, 32'hC0, 0, 0, 1,   0, 32'h00, NOPI,   0, 0};
    tv[17] = '{1, 32'h24, 32'hC4, 0, 0, 1,   1, 32'h20, 32'hC0, 1, 0};
    tv[18] = '{1, 32'h28, 32'hC8, 0, 1, 1,   1, 32'h20, 32'hC0, 2, 0};
    tv[19] = '{1, 32'h30, 32'hD0, 0, 0, 0,   0, 32'h00, NOPI,   0, 0};
    tv[20] = '{0, 32'h00, 32'h00, 0, 0, 0,   1, 32'h30, 32'hD0, 1, 1};
    tv[21] = '{0, 32'h00, 32'h00, 0, 0, 0,   0, 32'h00, NOPI,   0, 1};

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #22 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 22; i++) begin
      drive(tv[i].mv, tv[i].pc, tv[i].ins, tv[i].br, tv[i].pw, tv[i].sd);
      @(negedge clk);
      chk_all($sformatf("vec%0d", i), tv[i].e_v, tv[i].e_pc, tv[i].e_ins, tv[i].e_lvl, tv[i].e_st);
      @(posedge clk); #1;
    end

    // Async reset mid-stream with the queue full and fetch still valid.
    drive(1, 32'h40, 32'hE0, 0, 0, 1);
    @(posedge clk); #1;
    drive(1, 32'h44, 32'hE4, 0, 0, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_rst.level", 32'(level), 32'd2);
    #2 rst_n = 1'b0;
    #1 chk_all("async_rst", 1'b0, 32'h0, NOPI, 0, 1'b1);
    @(posedge clk); #1;
    chk_all("in_rst", 1'b0, 32'h0, NOPI, 0, 1'b1);
    drive(0, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Random traffic against the reference queue.
    q.delete();
    for (int c = 0; c < 3000; c++) begin
      logic mv, br, pw, sd, flush, ev, full, popm, pushm, est;
      logic [31:0] rpc, rins;
      mv  = ($urandom_range(99) < 75);
      sd  = ($urandom_range(99) < 35);
      br  = ($urandom_range(99) < 5);
      pw  = ($urandom_range(99) < 5);
      rpc = $urandom; rins = $urandom;
      drive(mv, rpc, rins, br, pw, sd);

      flush = br | pw;
      ev    = (q.size() > 0);
      full  = (q.size() == DEPTH);
      popm  = ev & ~sd;
      pushm = mv & ~flush & (~full | popm);
      est   = ~flush & (~mv | (full & ~popm));

      @(negedge clk);
      chk_all($sformatf("rnd%0d", c), ev, ev ? q[0][63:32] : 32'h0,
              ev ? q[0][31:0] : NOPI, q.size(), est);
      @(posedge clk); #1;

      if (flush) q.delete();
      else begin
        if (popm)  void'(q.pop_front());
        if (pushm) q.push_back({rpc, rins});
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
